alu_cmd_sequencer: RTL

Upstream/downstream companion to the 8-bit combinational ALU (ports A, B, MODE[2:0], OUT). Accepts operation commands over a valid/ready interface and sources operands from a small internal register file or an immediate. Drives the ALU's A/B/MODE from registers, captures OUT one cycle later and writes it back to the file. Publishes each result on a valid/ready result port, giving the combinational ALU a clocked command/result wrapper.

---
 rtl/alu_cmd_sequencer.sv | 119 +++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// Clocked command/result wrapper around an external combinational ALU.
// Commands read operands from a small register file or an immediate; results are written back and published.
module alu_cmd_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREG  = 4,
  parameter int unsigned RAW   = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic             CMD_LOAD,
  input  logic [2:0]       CMD_MODE,
  input  logic [RAW-1:0]   CMD_SRCA,
  input  logic [RAW-1:0]   CMD_SRCB,
  input  logic             CMD_USE_IMM,
  input  logic [WIDTH-1:0] CMD_IMM,
  input  logic [RAW-1:0]   CMD_DST,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [2:0]       ALU_MODE,
  input  logic [WIDTH-1:0] ALU_OUT,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [WIDTH-1:0] RES_DATA,
  output logic [RAW-1:0]   RES_DST,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_regs [NREG];
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [2:0]       r_alu_mode;
  logic [RAW-1:0]   r_dst;
  logic [WIDTH-1:0] r_res_data;
  logic [RAW-1:0]   r_res_dst;
  logic             r_res_valid;
  logic             r_busy;
  logic             w_cmd_ready;
  logic             w_accept;

  // Ready is gated by RST so a command presented during reset is never taken.
  assign w_cmd_ready = (r_state == S_IDLE) && !RST;
  assign w_accept    = CMD_VALID && w_cmd_ready;

  assign CMD_READY = w_cmd_ready;
  assign ALU_A     = r_alu_a;
  assign ALU_B     = r_alu_b;
  assign ALU_MODE  = r_alu_mode;
  assign RES_VALID = r_res_valid;
  assign RES_DATA  = r_res_data;
  assign RES_DST   = r_res_dst;
  assign BUSY      = r_busy;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_mode  <= '0;
      r_dst       <= '0;
      r_res_data  <= '0;
      r_res_dst   <= '0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_busy <= 1'b1;
            if (CMD_LOAD) begin
              r_res_data      <= CMD_IMM;
              r_res_dst       <= CMD_DST;
              r_regs[CMD_DST] <= CMD_IMM;
              r_res_valid     <= 1'b1;
              r_state         <= S_WB;
            end else begin
              r_alu_a    <= r_regs[CMD_SRCA];
              r_alu_b    <= CMD_USE_IMM ? CMD_IMM : r_regs[CMD_SRCB];
              r_alu_mode <= CMD_MODE;
              r_dst      <= CMD_DST;
              r_state    <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          r_res_data    <= ALU_OUT;
          r_res_dst     <= r_dst;
          r_regs[r_dst] <= ALU_OUT;
          r_res_valid   <= 1'b1;
          r_state       <= S_WB;
        end
        S_WB: begin
          if (RES_READY) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
